// File: rtl/cs_seq_if.sv
// Handshake bundle for cs_seq: command input, init chain, ADC loop, UDP tx and status.
// Handshakes: every fs is a level held high until its fd is sampled high; the fd is accepted on that edge.
interface cs_seq_if #(
  parameter int NUM_INIT = 5,
  parameter int DEV_W    = 3,
  parameter int CNT_W    = 8
);
  logic                fs_udp_rx;
  logic                fs_adc;
  logic [CNT_W-1:0]    pkt_num;
  logic                dev_grp;
  logic [DEV_W-1:0]    dev_num_ext;
  logic [NUM_INIT-1:0] fs_init;
  logic [NUM_INIT-1:0] fd_init;
  logic                fs_adc_conf;
  logic                fd_adc_conf;
  logic                fs_adc_read;
  logic                fd_adc_read;
  logic                fs_adc_fifo;
  logic                fd_adc_fifo;
  logic                fs_udp_tx;
  logic                fd_udp_tx;
  logic [DEV_W-1:0]    dev_num;
  logic [1:0]          main_state;
  logic                err;
  logic [2:0]          err_code;
  logic [2:0]          adc_state_dbg;
  logic                mac_state_dbg;

  modport master (
    input  fs_udp_rx, fs_adc, pkt_num, dev_grp, dev_num_ext,
    input  fd_init, fd_adc_conf, fd_adc_read, fd_adc_fifo, fd_udp_tx,
    output fs_init, fs_adc_conf, fs_adc_read, fs_adc_fifo, fs_udp_tx,
    output dev_num, main_state, err, err_code, adc_state_dbg, mac_state_dbg
  );

  modport slave (
    output fs_udp_rx, fs_adc, pkt_num, dev_grp, dev_num_ext,
    output fd_init, fd_adc_conf, fd_adc_read, fd_adc_fifo, fd_udp_tx,
    input  fs_init, fs_adc_conf, fs_adc_read, fs_adc_fifo, fs_udp_tx,
    input  dev_num, main_state, err, err_code, adc_state_dbg, mac_state_dbg
  );
endinterface

// File: rtl/cs_seq.sv
// MAC-RX command/sequence controller: N-stage init chain, per-tick ADC loop, packetised UDP tx,
// with watchdog, overrun and packet-drop reporting.
module cs_seq #(
  parameter int NUM_INIT = 5,
  parameter int NUM_DEV  = 8,
  parameter int CNT_W    = 8,
  parameter int TO_W     = 16,
  parameter int DEV_W    = $clog2(NUM_DEV)
) (
  input  logic     clk,
  input  logic     rst,
  cs_seq_if.master bus
);
  localparam int SW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
  localparam logic [SW-1:0]    LAST_STAGE = SW'(NUM_INIT - 1);
  localparam logic [DEV_W-1:0] LAST_DEV   = DEV_W'(NUM_DEV - 1);
  localparam logic [TO_W-1:0]  WD_MAX     = '1;

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_INIT = 2'd1, M_WORK = 2'd2, M_ERR = 2'd3} main_e;
  typedef enum logic [2:0] {A_IDLE, A_CONF, A_WAIT, A_READ, A_FIFO} adc_e;
  typedef enum logic {T_PREP, T_SEND} mac_e;

  main_e main_q, main_d;
  adc_e  adc_q, adc_d;
  mac_e  mac_q, mac_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [NUM_INIT-1:0] fs_init_q, fs_init_d;
  logic                conf_q, conf_d, read_q, read_d, fifo_q, fifo_d, tx_q, tx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, lim_q, lim_d;
  logic                pend_q, pend_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                prev_q, prev_d;
  logic [TO_W-1:0]     wd_q, wd_d;

  logic edge_seen, fd_acc, fs_held, fs_rise, sample_done;

  assign edge_seen = bus.fs_adc & ~prev_q;
  assign fs_held   = (fs_init_q != '0) | conf_q | read_q | fifo_q | tx_q;
  assign fd_acc    = (main_q == M_INIT && fs_init_q != '0 && bus.fd_init[stage_q])
                   | (adc_q == A_CONF && bus.fd_adc_conf)
                   | (adc_q == A_READ && bus.fd_adc_read)
                   | (adc_q == A_FIFO && bus.fd_adc_fifo)
                   | (mac_q == T_SEND && bus.fd_udp_tx);

  always_comb begin
    main_d     = main_q;
    adc_d      = adc_q;
    mac_d      = mac_q;
    stage_d    = stage_q;
    fs_init_d  = fs_init_q;
    conf_d     = conf_q;
    read_d     = read_q;
    fifo_d     = fifo_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    lim_d      = lim_q;
    pend_d     = pend_q;
    dev_d      = dev_q;
    err_code_d = err_code_q;
    prev_d     = bus.fs_adc;
    wd_d       = wd_q;
    sample_done = 1'b0;
    fs_rise     = 1'b0;

    case (main_q)
      M_INIT: begin
        if (fs_init_q == '0) begin
          fs_init_d = NUM_INIT'(1) << stage_q;
        end else if (bus.fd_init[stage_q]) begin
          if (stage_q == LAST_STAGE) begin
            fs_init_d = '0;
            main_d    = M_WORK;
            lim_d     = (bus.pkt_num == '0) ? CNT_W'(1) : bus.pkt_num;
          end else begin
            stage_d   = stage_q + 1'b1;
            fs_init_d = fs_init_q << 1;
          end
        end
      end
      M_WORK: begin
        case (adc_q)
          A_IDLE: begin adc_d = A_CONF; conf_d = 1'b1; end
          A_CONF: if (bus.fd_adc_conf) begin adc_d = A_WAIT; conf_d = 1'b0; end
          A_WAIT: if (edge_seen) begin
            adc_d  = A_READ;
            read_d = 1'b1;
            dev_d  = (dev_q == LAST_DEV) ? '0 : dev_q + 1'b1;
          end
          A_READ: if (bus.fd_adc_read) begin adc_d = A_FIFO; read_d = 1'b0; fifo_d = 1'b1; end
          A_FIFO: if (bus.fd_adc_fifo) begin adc_d = A_WAIT; fifo_d = 1'b0; sample_done = 1'b1; end
          default: adc_d = A_IDLE;
        endcase
        // A tick arriving while a handshake is still open is lost, not queued.
        if (edge_seen && (adc_q == A_CONF || adc_q == A_READ || adc_q == A_FIFO))
          err_code_d[1] = 1'b1;
        if (mac_q == T_PREP) begin
          if (pend_q) begin mac_d = T_SEND; tx_d = 1'b1; pend_d = 1'b0; end
        end else if (bus.fd_udp_tx) begin
          mac_d = T_PREP;
          tx_d  = 1'b0;
        end
        if (sample_done) begin
          if (cnt_q + CNT_W'(1) == lim_q) begin
            cnt_d = '0;
            // Pending is only still owned here if the sender is busy; otherwise it is consumed this cycle.
            if (pend_q && mac_q == T_SEND) err_code_d[2] = 1'b1;
            else pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if ((main_q == M_INIT || main_q == M_WORK) && wd_q == WD_MAX && fs_held && !fd_acc) begin
      main_d        = M_ERR;
      fs_init_d     = '0;
      conf_d        = 1'b0;
      read_d        = 1'b0;
      fifo_d        = 1'b0;
      tx_d          = 1'b0;
      adc_d         = A_IDLE;
      mac_d         = T_PREP;
      err_code_d[0] = 1'b1;
    end

    if (bus.fs_udp_rx) begin
      main_d     = M_INIT;
      stage_d    = '0;
      fs_init_d  = '0;
      conf_d     = 1'b0;
      read_d     = 1'b0;
      fifo_d     = 1'b0;
      tx_d       = 1'b0;
      adc_d      = A_IDLE;
      mac_d      = T_PREP;
      cnt_d      = '0;
      pend_d     = 1'b0;
      dev_d      = '0;
      err_code_d = '0;
    end

    fs_rise = ((fs_init_d & ~fs_init_q) != '0) | (conf_d & ~conf_q) | (read_d & ~read_q)
            | (fifo_d & ~fifo_q) | (tx_d & ~tx_q);
    if (fs_rise || fd_acc) wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= M_IDLE;
      adc_q      <= A_IDLE;
      mac_q      <= T_PREP;
      stage_q    <= '0;
      fs_init_q  <= '0;
      conf_q     <= 1'b0;
      read_q     <= 1'b0;
      fifo_q     <= 1'b0;
      tx_q       <= 1'b0;
      cnt_q      <= '0;
      lim_q      <= CNT_W'(1);
      pend_q     <= 1'b0;
      dev_q      <= '0;
      err_code_q <= '0;
      prev_q     <= 1'b1;
      wd_q       <= '0;
    end else begin
      main_q     <= main_d;
      adc_q      <= adc_d;
      mac_q      <= mac_d;
      stage_q    <= stage_d;
      fs_init_q  <= fs_init_d;
      conf_q     <= conf_d;
      read_q     <= read_d;
      fifo_q     <= fifo_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      pend_q     <= pend_d;
      dev_q      <= dev_d;
      err_code_q <= err_code_d;
      prev_q     <= prev_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.fs_init       = fs_init_q;
  assign bus.fs_adc_conf   = conf_q;
  assign bus.fs_adc_read   = read_q;
  assign bus.fs_adc_fifo   = fifo_q;
  assign bus.fs_udp_tx     = tx_q;
  assign bus.main_state    = main_q;
  assign bus.err_code      = err_code_q;
  assign bus.err           = |err_code_q;
  assign bus.dev_num       = bus.dev_grp ? bus.dev_num_ext : dev_q;
  assign bus.adc_state_dbg = adc_q;
  assign bus.mac_state_dbg = mac_q;
endmodule

// File: tb/tb_cs_seq.sv
// Directed bench for cs_seq: init walk, packet cadence table, overrun, drop, timeout and reset-with-tick.
module tb_cs_seq;
  localparam int NUM_INIT = 5;
  localparam int DEV_W    = 3;
  localparam int CNT_W    = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   tx_total = 0;
  int   base;
  logic tx_prev;
  logic en_conf, en_read, en_fifo, en_tx;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] pkt;
    int         ticks;
    logic       grp;
    logic [2:0] ext;
    int         exp_tx;
    logic [2:0] exp_dev;
  } row_t;
  row_t rows[5];

  cs_seq_if #(.NUM_INIT(NUM_INIT), .DEV_W(DEV_W), .CNT_W(CNT_W)) bus ();

  cs_seq #(.NUM_INIT(NUM_INIT), .NUM_DEV(8), .CNT_W(CNT_W), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Responders for the ADC and tx handshakes: fd answers in the same cycle fs is seen, when enabled.
  assign bus.fd_adc_conf = bus.fs_adc_conf & en_conf;
  assign bus.fd_adc_read = bus.fs_adc_read & en_read;
  assign bus.fd_adc_fifo = bus.fs_adc_fifo & en_fifo;
  assign bus.fd_udp_tx   = bus.fs_udp_tx & en_tx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tx_prev <= 1'b0;
    else begin
      tx_prev <= bus.fs_udp_tx;
      if (bus.fs_udp_tx && !tx_prev) tx_total <= tx_total + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_init();
    logic [NUM_INIT-1:0] oh;
    bus.fs_udp_rx = 1'b1;
    @(negedge clk);
    bus.fs_udp_rx = 1'b0;
    chk("init_main", 32'(bus.main_state), 1);
    chk("init_err_clear", 32'(bus.err), 0);
    chk("init_fs_gap", 32'(bus.fs_init), 0);
    @(negedge clk);
    for (int i = 0; i < NUM_INIT; i++) begin
      oh = NUM_INIT'(1) << i;
      chk("init_walk", 32'(bus.fs_init), 32'(oh));
      bus.fd_init = ~oh;
      repeat (2) @(negedge clk);
      chk("init_hold", 32'(bus.fs_init), 32'(oh));
      bus.fd_init = oh;
      @(negedge clk);
      bus.fd_init = '0;
    end
    chk("init_done_main", 32'(bus.main_state), 2);
    chk("init_done_fs", 32'(bus.fs_init), 0);
    chk("init_done_err", 32'(bus.err), 0);
  endtask

  task automatic do_tick();
    bus.fs_adc = 1'b1;
    repeat (2) @(negedge clk);
    bus.fs_adc = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rows[0] = '{pkt: 8'd0,   ticks: 4, grp: 1'b0, ext: 3'd0, exp_tx: 4, exp_dev: 3'd4};
    rows[1] = '{pkt: 8'd1,   ticks: 3, grp: 1'b0, ext: 3'd0, exp_tx: 3, exp_dev: 3'd3};
    rows[2] = '{pkt: 8'd5,   ticks: 9, grp: 1'b0, ext: 3'd0, exp_tx: 1, exp_dev: 3'd1};
    rows[3] = '{pkt: 8'd2,   ticks: 5, grp: 1'b1, ext: 3'd5, exp_tx: 2, exp_dev: 3'd5};
    rows[4] = '{pkt: 8'd255, ticks: 3, grp: 1'b1, ext: 3'd2, exp_tx: 0, exp_dev: 3'd2};

    // Reset with the sample tick already high.
    rst = 1'b1;
    bus.fs_udp_rx = 1'b0; bus.fs_adc = 1'b1; bus.pkt_num = 8'd1;
    bus.dev_grp = 1'b0; bus.dev_num_ext = '0; bus.fd_init = '0;
    en_conf = 1'b1; en_read = 1'b1; en_fifo = 1'b1; en_tx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_main", 32'(bus.main_state), 0);
    chk("rst_fs_init", 32'(bus.fs_init), 0);
    chk("rst_fs_adc", 32'({bus.fs_adc_conf, bus.fs_adc_read, bus.fs_adc_fifo, bus.fs_udp_tx}), 0);
    chk("rst_err", 32'({bus.err, bus.err_code}), 0);
    chk("rst_dev", 32'(bus.dev_num), 0);

    run_init();
    repeat (5) @(negedge clk);
    chk("held_tick_no_read", 32'(bus.fs_adc_read), 0);
    chk("held_tick_dev", 32'(bus.dev_num), 0);
    bus.fs_adc = 1'b0;
    @(negedge clk);
    bus.fs_adc = 1'b1;
    @(negedge clk);
    chk("lat_read", 32'(bus.fs_adc_read), 1);
    chk("lat_dev", 32'(bus.dev_num), 1);
    @(negedge clk);
    chk("lat_fifo", 32'({bus.fs_adc_read, bus.fs_adc_fifo}), 1);
    @(negedge clk);
    chk("lat_tx_early", 32'(bus.fs_udp_tx), 0);
    @(negedge clk);
    chk("lat_tx", 32'(bus.fs_udp_tx), 1);
    bus.fs_adc = 1'b0;
    repeat (4) @(negedge clk);

    // Packet cadence with pkt_num=3 over nine ticks.
    bus.pkt_num = 8'd3;
    run_init();
    repeat (4) @(negedge clk);
    base = tx_total;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back(3'(k % 8));
      do_tick();
      chk("cad_dev", 32'(bus.dev_num), 32'(exp_q.pop_front()));
      chk("cad_tx", 32'(tx_total - base), 32'(k / 3));
    end
    chk("cad_err", 32'(bus.err_code), 0);

    for (int r = 0; r < 5; r++) begin
      bus.pkt_num = rows[r].pkt;
      bus.dev_grp = rows[r].grp;
      bus.dev_num_ext = rows[r].ext;
      run_init();
      repeat (4) @(negedge clk);
      base = tx_total;
      for (int k = 1; k <= rows[r].ticks; k++) begin
        exp_q.push_back(rows[r].grp ? rows[r].ext : 3'(k % 8));
        do_tick();
        chk("row_dev_tick", 32'(bus.dev_num), 32'(exp_q.pop_front()));
      end
      chk("row_tx_count", 32'(tx_total - base), 32'(rows[r].exp_tx));
      chk("row_dev_final", 32'(bus.dev_num), 32'(rows[r].exp_dev));
      chk("row_err_code", 32'(bus.err_code), 0);
      chk("row_main", 32'(bus.main_state), 2);
    end
    bus.dev_grp = 1'b0;

    // Overrun: a second tick while READ is still open.
    bus.pkt_num = 8'd3;
    run_init();
    repeat (4) @(negedge clk);
    en_read = 1'b0;
    bus.fs_adc = 1'b1;
    @(negedge clk);
    chk("ovr_read", 32'(bus.fs_adc_read), 1);
    bus.fs_adc = 1'b0;
    @(negedge clk);
    bus.fs_adc = 1'b1;
    @(negedge clk);
    chk("ovr_code", 32'(bus.err_code), 3'b010);
    chk("ovr_err", 32'(bus.err), 1);
    chk("ovr_dev", 32'(bus.dev_num), 1);
    chk("ovr_read_hold", 32'(bus.fs_adc_read), 1);
    en_read = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovr_back_wait", 32'({bus.fs_adc_read, bus.fs_adc_fifo}), 0);
    bus.fs_adc = 1'b0;
    repeat (2) @(negedge clk);
    do_tick();
    chk("ovr_continue_dev", 32'(bus.dev_num), 2);
    chk("ovr_code_sticky", 32'(bus.err_code), 3'b010);
    chk("ovr_main", 32'(bus.main_state), 2);

    // Drop: tx held off across two further packet completions.
    bus.pkt_num = 8'd1;
    run_init();
    repeat (4) @(negedge clk);
    en_tx = 1'b0;
    base = tx_total;
    repeat (3) do_tick();
    chk("drop_code", 32'(bus.err_code), 3'b100);
    chk("drop_tx_held", 32'(bus.fs_udp_tx), 1);
    chk("drop_tx_count", 32'(tx_total - base), 1);
    en_tx = 1'b1;
    repeat (6) @(negedge clk);
    chk("drop_one_queued", 32'(tx_total - base), 2);
    chk("drop_tx_idle", 32'(bus.fs_udp_tx), 0);
    chk("drop_code_sticky", 32'(bus.err_code), 3'b100);

    // Timeout: configure handshake never answered.
    en_conf = 1'b0;
    run_init();
    repeat (10) @(negedge clk);
    chk("to_still_work", 32'(bus.main_state), 2);
    chk("to_conf_held", 32'(bus.fs_adc_conf), 1);
    for (int n = 0; n < 12 && bus.main_state != 2'd3; n++) @(negedge clk);
    chk("to_main_err", 32'(bus.main_state), 3);
    chk("to_fs_clear", 32'({bus.fs_init, bus.fs_adc_conf, bus.fs_adc_read, bus.fs_adc_fifo, bus.fs_udp_tx}), 0);
    chk("to_code", 32'(bus.err_code), 3'b001);
    chk("to_err", 32'(bus.err), 1);
    repeat (3) @(negedge clk);
    chk("to_stays_err", 32'(bus.main_state), 3);
    en_conf = 1'b1;
    run_init();
    chk("to_restart_code", 32'(bus.err_code), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
